// File: rtl/result_streamer_if.sv
// Valid/ready word stream carrying the serialised result frame toward the host link.
interface result_streamer_if #(
  parameter int unsigned POSBITS = 9
) ();
  logic [POSBITS-1:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_header;
  logic               out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_header,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_header,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/result_streamer.sv
// Snapshots the stored ruler results when the search finishes and streams them as
// one header word (raw count) followed by every mark of every stored result.
module result_streamer #(
  parameter int unsigned NUMPOSITIONS = 5,
  parameter int unsigned POSBITS      = 9,
  parameter int unsigned NUMRESULTS   = 5
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic                                             done,
  input  logic [5:0]                                       numResultsObserved,
  input  logic [(NUMPOSITIONS+1)*POSBITS*NUMRESULTS-1:0]   results,
  result_streamer_if.master                                strm,
  output logic                                             overflow,
  output logic                                             busy
);

  localparam int unsigned MARKS_PER = NUMPOSITIONS + 1;
  localparam int unsigned SHADOW_W  = MARKS_PER * POSBITS * NUMRESULTS;
  localparam int unsigned IW        = $clog2(NUMRESULTS + 1);
  localparam int unsigned JW        = (NUMPOSITIONS > 0) ? $clog2(NUMPOSITIONS + 1) : 1;

  localparam logic [5:0]    NR_CNT = 6'(NUMRESULTS);
  localparam logic [IW-1:0] NR_IDX = IW'(NUMRESULTS);
  localparam logic [JW-1:0] J_LAST = JW'(NUMPOSITIONS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HEADER = 2'd1,
    S_MARKS  = 2'd2,
    S_HOLD   = 2'd3
  } state_e;

  state_e                state_q,    state_d;
  logic [SHADOW_W-1:0]   shadow_q,   shadow_d;
  logic [IW-1:0]         n_q,        n_d;
  logic [IW-1:0]         i_q,        i_d;
  logic [JW-1:0]         j_q,        j_d;
  logic                  overflow_q, overflow_d;
  logic [POSBITS-1:0]    data_q,     data_d;
  logic                  valid_q,    valid_d;
  logic                  header_q,   header_d;
  logic                  last_q,     last_d;
  logic                  busy_q,     busy_d;
  logic                  xfer;

  // Shadow shifts left one word per transfer, so its top word is always the next mark.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    n_d        = n_q;
    i_d        = i_q;
    j_d        = j_q;
    overflow_d = overflow_q;
    data_d     = data_q;
    valid_d    = valid_q;
    header_d   = header_q;
    last_d     = last_q;
    xfer       = valid_q && strm.out_ready;

    unique case (state_q)
      S_IDLE: begin
        if (done) begin
          shadow_d   = results;
          overflow_d = (numResultsObserved > NR_CNT);
          n_d        = (numResultsObserved > NR_CNT) ? NR_IDX : IW'(numResultsObserved);
          data_d     = POSBITS'(numResultsObserved);
          valid_d    = 1'b1;
          header_d   = 1'b1;
          last_d     = (n_d == '0);
          state_d    = S_HEADER;
        end
      end

      S_HEADER: begin
        if (xfer) begin
          header_d = 1'b0;
          if (n_q == '0) begin
            state_d = S_HOLD;
            valid_d = 1'b0;
            last_d  = 1'b0;
            data_d  = '0;
          end else begin
            state_d  = S_MARKS;
            i_d      = IW'(1);
            j_d      = '0;
            data_d   = shadow_q[SHADOW_W-1 -: POSBITS];
            shadow_d = shadow_q << POSBITS;
            last_d   = (i_d == n_q) && (j_d == J_LAST);
          end
        end
      end

      S_MARKS: begin
        if (xfer) begin
          if (last_q) begin
            state_d = S_HOLD;
            valid_d = 1'b0;
            last_d  = 1'b0;
            data_d  = '0;
          end else begin
            if (j_q == J_LAST) begin
              j_d = '0;
              i_d = i_q + IW'(1);
            end else begin
              j_d = j_q + JW'(1);
            end
            data_d   = shadow_q[SHADOW_W-1 -: POSBITS];
            shadow_d = shadow_q << POSBITS;
            last_d   = (i_d == n_q) && (j_d == J_LAST);
          end
        end
      end

      S_HOLD: begin
        // Wait for done to drop so a single done level yields a single frame.
        if (!done) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_HEADER) || (state_d == S_MARKS);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      shadow_q   <= '0;
      n_q        <= '0;
      i_q        <= '0;
      j_q        <= '0;
      overflow_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      header_q   <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      n_q        <= n_d;
      i_q        <= i_d;
      j_q        <= j_d;
      overflow_q <= overflow_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      header_q   <= header_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
    end
  end

  assign strm.out_data   = data_q;
  assign strm.out_valid  = valid_q;
  assign strm.out_header = header_q;
  assign strm.out_last   = last_q;
  assign overflow        = overflow_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_result_streamer.sv
// Directed bench for result_streamer: expected frames are queued when done is raised
// and compared beat by beat as words transfer.
module tb_result_streamer;
  localparam int unsigned NP = 5;
  localparam int unsigned PB = 9;
  localparam int unsigned NR = 5;
  localparam int unsigned RW = (NP + 1) * PB;
  localparam int unsigned W  = RW * NR;

  typedef struct packed {
    logic [PB-1:0] d;
    logic          h;
    logic          l;
  } beat_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          done;
  logic [5:0]    cnt_in;
  logic [W-1:0]  results;
  logic          overflow;
  logic          busy;

  beat_t         exp_q[$];
  logic [PB-1:0] rr [1:NR][0:NP];
  int            passed = 0;
  int            failed = 0;
  int            total  = 0;
  int            beats;
  int            vcount;

  always #5 clock = ~clock;

  result_streamer_if #(.POSBITS(PB)) s_if ();

  result_streamer #(
    .NUMPOSITIONS(NP),
    .POSBITS     (PB),
    .NUMRESULTS  (NR)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .done              (done),
    .numResultsObserved(cnt_in),
    .results           (results),
    .strm              (s_if),
    .overflow          (overflow),
    .busy              (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_results();
    logic [W-1:0] v;
    v = '0;
    for (int i = 1; i <= int'(NR); i++)
      for (int j = 0; j <= int'(NP); j++)
        v[W-1-((i-1)*(int'(NP)+1)+j)*int'(PB) -: PB] = rr[i][j];
    return v;
  endfunction

  task automatic push_frame(input int cnt);
    int n;
    beat_t b;
    n = (cnt > int'(NR)) ? int'(NR) : cnt;
    b.d = PB'(cnt);
    b.h = 1'b1;
    b.l = (n == 0);
    exp_q.push_back(b);
    for (int i = 1; i <= n; i++)
      for (int j = 0; j <= int'(NP); j++) begin
        b.d = rr[i][j];
        b.h = 1'b0;
        b.l = (i == n) && (j == int'(NP));
        exp_q.push_back(b);
      end
  endtask

  // Entered just after the capture edge; consumes the queued frame with bounded cycles.
  task automatic run_frame(input bit rand_ready, input int budget, output int nbeats);
    beat_t prev, cur, e;
    bit    stalled;
    int    cyc;
    stalled = 1'b0;
    cyc     = 0;
    nbeats  = 0;
    prev    = '0;
    while (exp_q.size() > 0 && cyc < budget) begin
      cur.d = s_if.out_data;
      cur.h = s_if.out_header;
      cur.l = s_if.out_last;
      if (stalled) check("stall_hold", {s_if.out_valid, cur}, {1'b1, prev});
      check("valid_busy", {s_if.out_valid, busy}, 2'b11);
      s_if.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = s_if.out_valid && !s_if.out_ready;
      prev    = cur;
      if (s_if.out_valid && s_if.out_ready) begin
        e = exp_q.pop_front();
        check("beat", cur, e);
        nbeats++;
      end
      @(posedge clock); #1;
      cyc++;
    end
    check("frame_complete", exp_q.size(), 0);
    exp_q.delete();
    check("idle_after", {s_if.out_valid, busy}, 2'b00);
  endtask

  task automatic drop_done();
    done = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
  endtask

  initial begin
    reset          = 1'b1;
    done           = 1'b0;
    cnt_in         = '0;
    results        = '0;
    s_if.out_ready = 1'b0;
    for (int i = 1; i <= int'(NR); i++)
      for (int j = 0; j <= int'(NP); j++)
        rr[i][j] = PB'((i * 37 + j * 53) % 512);

    #2 reset = 1'b0;
    #2;
    check("reset_outs", {s_if.out_valid, s_if.out_header, s_if.out_last, s_if.out_data,
                         overflow, busy}, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    check("idle_no_valid", s_if.out_valid, 0);

    // Single result
    rr[1] = '{9'd0, 9'd1, 9'd4, 9'd10, 9'd12, 9'd17};
    results = pack_results();
    cnt_in  = 6'd1;
    push_frame(1);
    done = 1'b1;
    @(posedge clock); #1;
    run_frame(1'b0, 20, beats);
    check("single_beats", beats, 7);
    check("single_ovf", overflow, 0);

    // done held high: no further frames
    vcount = 0;
    repeat (100) begin
      s_if.out_ready = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
      if (s_if.out_valid) vcount++;
    end
    check("no_retrigger", vcount, 0);
    drop_done();
    push_frame(1);
    done = 1'b1;
    @(posedge clock); #1;
    run_frame(1'b0, 20, beats);
    check("retrigger_beats", beats, 7);
    vcount = 0;
    repeat (20) begin @(posedge clock); #1; if (s_if.out_valid) vcount++; end
    check("one_frame_only", vcount, 0);
    drop_done();

    // Empty frame
    cnt_in = 6'd0;
    push_frame(0);
    done = 1'b1;
    @(posedge clock); #1;
    run_frame(1'b0, 5, beats);
    check("empty_beats", beats, 1);
    check("empty_ovf", overflow, 0);
    drop_done();

    // Backpressure with inputs corrupted after capture
    rr[2] = '{9'd0, 9'd2, 9'd7, 9'd13, 9'd16, 9'd17};
    results = pack_results();
    cnt_in  = 6'd2;
    push_frame(2);
    done = 1'b1;
    @(posedge clock); #1;
    results = ~results;
    cnt_in  = 6'd63;
    run_frame(1'b1, 300, beats);
    check("bp_beats", beats, 13);
    drop_done();

    // Overflow: count above slot count
    results = pack_results();
    cnt_in  = 6'd7;
    push_frame(7);
    done = 1'b1;
    @(posedge clock); #1;
    check("ovf_flag", overflow, 1);
    run_frame(1'b0, 60, beats);
    check("ovf_beats", beats, 31);
    check("ovf_hold", overflow, 1);
    drop_done();

    // Reset mid-frame during the 4th mark word
    cnt_in = 6'd1;
    done   = 1'b1;
    s_if.out_ready = 1'b1;
    @(posedge clock); #1;
    repeat (4) begin @(posedge clock); #1; end
    check("mark4_shown", s_if.out_data, rr[1][3]);
    #2 reset = 1'b0;
    #1;
    check("async_reset", {s_if.out_valid, s_if.out_header, s_if.out_last, s_if.out_data,
                          overflow, busy}, 0);
    @(negedge clock);
    reset = 1'b1;
    push_frame(1);
    @(posedge clock); #1;
    run_frame(1'b0, 20, beats);
    check("post_reset_beats", beats, 7);
    drop_done();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/result_streamer.md
# result_streamer

Downstream of `assembly`, `result_streamer` takes the search outcome once the search raises `done`. It snapshots the stored optimal-ruler results and the result count, then serialises them as a valid/ready word stream toward the host interface. The stream replaces the `$display` dump used in simulation with something an FPGA host link can consume. The frame is one header word (result count) followed by every mark of every stored result.

## Interface
Parameters:
- `NUMPOSITIONS`, 5, index of the last mark; each result holds `NUMPOSITIONS+1` marks.
- `POSBITS`, 9, width of one mark value (`PositionValueBitMaxPlus1`). Must be ≥ 6.
- `NUMRESULTS`, 5, result slots in `results` (`NumResultsStored`).

Ports:
- `clock`  in  1  single clock; all state changes on posedge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `done`  in  1  search finished (level, from `assembly`).
- `numResultsObserved`  in  6  number of rulers found.
- `results`  in  (NUMPOSITIONS+1)*POSBITS*NUMRESULTS  packed results. r[1] is the most significant slice; within r[i], m[0] is the most significant POSBITS.
- `out_data`  out  POSBITS  current word.
- `out_valid`  out  1  word available.
- `out_ready`  in  1  consumer accepts word.
- `out_header`  out  1  current word is the header.
- `out_last`  out  1  current word is the final word of the frame.
- `overflow`  out  1  count exceeded `NUMRESULTS` in the captured frame.
- `busy`  out  1  frame in progress.

## Operation
- FSM states: IDLE, HEADER, MARKS, HOLD.
- **IDLE:**
  - If `done`=1 at a posedge, capture `results` into a shadow register and capture the count.
  - Set `n = min(count, NUMRESULTS)` and `overflow = (count > NUMRESULTS)`, then go to HEADER.
- **HEADER:**
  - `out_data` = count zero-extended to POSBITS (raw count, not clamped).
  - `out_header`=1 and `out_valid`=1.
  - `out_last`=1 iff n=0.
  - On transfer: go to HOLD if n=0, else go to MARKS with result index i=1 and mark index j=0.
- **MARKS:**
  - `out_data` = shadow r[i].m[j].
  - `out_last`=1 iff i=n and j=NUMPOSITIONS.
  - On transfer: j increments. When j wraps from NUMPOSITIONS to 0, i increments. After the last word, go to HOLD.
- **HOLD:** `out_valid`=0. Return to IDLE when `done`=0. This stops one `done` pulse from producing repeated frames.
- Transfer = `out_valid && out_ready` at a posedge. While `out_valid`=1 and `out_ready`=0, `out_data`, `out_header` and `out_last` hold stable.
- Changes on `results` or `numResultsObserved` after capture do not affect the frame in flight.
- `busy` = 1 in HEADER and MARKS.
- `overflow` holds its value until the next capture or reset.
- Frame length = 1 + n·(NUMPOSITIONS+1) words.

## Timing
- Reset (`reset`=0) asynchronously sets all outputs to 0, state to IDLE, and clears the shadow register and counters.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Capture latency: `done` sampled high at edge k gives `out_valid`=1 with the header from just after edge k.
- With `out_ready` held at 1, one word transfers per clock, with no bubbles between the header and marks or between results.
- `done` already high when reset releases: a capture occurs on the first posedge after release.
- Reset during HEADER or MARKS aborts the frame. Nothing resumes; the next frame starts again from the header.
- `out_ready` may change arbitrarily, including while `out_valid`=0; it is ignored in IDLE and HOLD.

## Test plan
- **Single result:** count=1, r[1]=0-1-4-10-12-17, `out_ready`=1, `done` raised.
  - Required: 7 consecutive beats: 1 (header), then 0, 1, 4, 10, 12, 17.
  - `out_last` set only on 17; `busy` falls the cycle after; `overflow`=0.
- **Empty:** count=0, `done`=1.
  - Required: a single beat 0 with `out_header`=1 and `out_last`=1, then HOLD.
- **Backpressure:** count=2, r[2]=0-2-7-13-16-17.
  - Stimulus: `out_ready` toggles 1,0,0,1,… pseudo-randomly.
  - Required: exactly 13 transfers in order 2, r[1] marks, r[2] marks; data stable while stalled.
  - Corrupt `results` after capture; the streamed values must not change.
- **Overflow:** count=7 with 5 slots filled.
  - Required: header 7, `overflow`=1, 31 beats total, last beat = r[5].m[5].
- **Reset mid-frame:** pull `reset` low during the 4th mark word.
  - Required: all outputs 0 immediately without waiting for a clock edge.
  - On release with `done` still 1: a fresh full frame starting from the header.
- **No retrigger:** hold `done`=1 for 100 cycles after the frame.
  - Required: no further `out_valid`.
  - Drop `done` then raise it again: exactly one new frame.
